// File: rtl/ai_core_collect_rank.sv
// Round-robin collector for N core distance FIFOs: ranks best/second-best class by
// minimum distance, applies threshold + margin rejection and raises a sticky done IRQ.
module ai_core_collect_rank #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned SUM_W   = 32,
    parameter int unsigned CLASS_W = 4,
    parameter int unsigned SCORE_W = 24
) (
    input  logic                       csi_clk,
    input  logic                       rsi_reset_n,
    input  logic                       init,
    input  logic [15:0]                cfg_count,
    input  logic [SCORE_W-1:0]         cfg_threshold,
    input  logic [SCORE_W-1:0]         cfg_margin,
    input  logic [N_CORES*SUM_W-1:0]   fsum_out,
    input  logic [N_CORES-1:0]         fsum_empty,
    output logic [N_CORES-1:0]         fsum_read,
    output logic [SCORE_W-1:0]         best_score,
    output logic [CLASS_W-1:0]         best_class,
    output logic [SCORE_W-1:0]         second_score,
    output logic [CLASS_W-1:0]         second_class,
    output logic [CLASS_W-1:0]         decision,
    output logic                       decision_valid,
    output logic                       busy,
    output logic                       done_irq,
    input  logic                       irq_ack
);

    localparam int unsigned PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic [CNT_W-1:0]     cfg_count_q;
    logic [SCORE_W-1:0]   thr_q;
    logic [SCORE_W-1:0]   margin_q;
    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic                 pop;
    logic [SUM_W-1:0]     pop_word;
    logic [SCORE_W-1:0]   pop_dist;
    logic [CLASS_W-1:0]   pop_class;
    logic [SCORE_W-1:0]   diff;
    logic                 accept_c;

    // First non-empty core at or after ptr, wrapping; returns {valid, index}.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_CORES-1:0] empty,
                                               input logic [PTR_W-1:0]   ptr);
        logic [PTR_W:0]     res;
        logic [N_CORES-1:0] shifted;
        int unsigned        idx;
        res = '0;
        for (int unsigned k = N_CORES; k > 0; k--) begin
            idx = 32'(ptr) + k - 32'd1;
            if (idx >= N_CORES) begin
                idx = idx - N_CORES;
            end
            shifted = empty >> idx;
            if (!shifted[0]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {grant_valid, grant_idx} = rr_pick(fsum_empty, rr_ptr);
        pop_word  = SUM_W'(fsum_out >> (32'(grant_idx) * SUM_W));
        pop_dist  = pop_word[SCORE_W-1:0];
        pop_class = pop_word[SUM_W-1 -: CLASS_W];
        rr_next   = (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    generate
        if (SUM_W > SCORE_W + CLASS_W) begin : g_gap
            logic unused_gap;
            assign unused_gap = ^pop_word[SUM_W-CLASS_W-1:SCORE_W];
        end
    endgenerate

    // An empty run (count 0) is always rejected, whatever the thresholds.
    always_comb begin
        diff     = second_score - best_score;
        accept_c = (cnt != '0) && (best_score <= thr_q) && (diff >= margin_q);
    end

    // Next-state and pop strobe; no pop in the init cycle so a restart loses no data.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        fsum_read  = '0;
        case (state)
            S_IDLE: begin
                if (init) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (init) begin
                    state_next = S_COLLECT;
                end else if (cnt == cfg_count_q) begin
                    state_next = S_DECIDE;
                end else begin
                    pop = grant_valid;
                end
            end
            S_DECIDE: begin
                state_next = init ? S_COLLECT : S_DONE;
            end
            S_DONE: begin
                if (init) state_next = S_COLLECT;
            end
            default: state_next = S_IDLE;
        endcase
        if (!rsi_reset_n) begin
            pop = 1'b0;
        end
        if (pop) begin
            fsum_read = N_CORES'(1) << grant_idx;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rr_ptr         <= '0;
            cfg_count_q    <= '0;
            thr_q          <= '0;
            margin_q       <= '0;
            best_score     <= '1;
            best_class     <= '0;
            second_score   <= '1;
            second_class   <= '0;
            decision       <= '1;
            decision_valid <= 1'b0;
            busy           <= 1'b0;
            done_irq       <= 1'b0;
        end else begin
            state          <= state_next;
            decision_valid <= (state_next == S_DONE);
            busy           <= (state_next == S_COLLECT) || (state_next == S_DECIDE);
            if (init) begin
                cfg_count_q  <= cfg_count;
                thr_q        <= cfg_threshold;
                margin_q     <= cfg_margin;
                cnt          <= '0;
                best_score   <= '1;
                best_class   <= '0;
                second_score <= '1;
                second_class <= '0;
                decision     <= '1;
                done_irq     <= 1'b0;
            end else begin
                // Strict less-than keeps the earlier entry on ties.
                if (pop) begin
                    cnt    <= cnt + CNT_W'(1);
                    rr_ptr <= rr_next;
                    if (pop_dist < best_score) begin
                        second_score <= best_score;
                        second_class <= best_class;
                        best_score   <= pop_dist;
                        best_class   <= pop_class;
                    end else if (pop_dist < second_score) begin
                        second_score <= pop_dist;
                        second_class <= pop_class;
                    end
                end
                if (state == S_DECIDE) begin
                    decision <= accept_c ? best_class : '1;
                end
                // Set on DONE entry wins over a coincident acknowledge.
                if (state == S_DECIDE) begin
                    done_irq <= 1'b1;
                end else if (irq_ack) begin
                    done_irq <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ai_core_collect_rank.sv
// Directed bench for ai_core_collect_rank: show-ahead FIFO models per core,
// a table of ranking/decision vectors plus hand-written multi-cycle sequences.
module tb_ai_core_collect_rank;

    localparam int unsigned N       = 4;
    localparam int unsigned SUM_W   = 32;
    localparam int unsigned CLASS_W = 4;
    localparam int unsigned SCORE_W = 24;
    localparam logic [SCORE_W-1:0] S_MAX = '1;
    localparam logic [CLASS_W-1:0] C_REJ = '1;

    logic                     csi_clk = 1'b0;
    logic                     rsi_reset_n;
    logic                     init;
    logic [15:0]              cfg_count;
    logic [SCORE_W-1:0]       cfg_threshold;
    logic [SCORE_W-1:0]       cfg_margin;
    logic [N*SUM_W-1:0]       fsum_out;
    logic [N-1:0]             fsum_empty;
    logic [N-1:0]             fsum_read;
    logic [SCORE_W-1:0]       best_score;
    logic [CLASS_W-1:0]       best_class;
    logic [SCORE_W-1:0]       second_score;
    logic [CLASS_W-1:0]       second_class;
    logic [CLASS_W-1:0]       decision;
    logic                     decision_valid;
    logic                     busy;
    logic                     done_irq;
    logic                     irq_ack;

    always #5 csi_clk = ~csi_clk;

    ai_core_collect_rank #(
        .N_CORES(N), .SUM_W(SUM_W), .CLASS_W(CLASS_W), .SCORE_W(SCORE_W)
    ) dut (
        .csi_clk(csi_clk), .rsi_reset_n(rsi_reset_n), .init(init),
        .cfg_count(cfg_count), .cfg_threshold(cfg_threshold), .cfg_margin(cfg_margin),
        .fsum_out(fsum_out), .fsum_empty(fsum_empty), .fsum_read(fsum_read),
        .best_score(best_score), .best_class(best_class),
        .second_score(second_score), .second_class(second_class),
        .decision(decision), .decision_valid(decision_valid), .busy(busy),
        .done_irq(done_irq), .irq_ack(irq_ack)
    );

    logic [SUM_W-1:0] fifo [N][$];
    int   pop_core [$];
    int   pop_cyc [$];
    int   cyc       = 0;
    int   pop_cnt   = 0;
    logic underflow = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    // FIFO models: pop on the strobe, present the new head right after the edge.
    always @(posedge csi_clk) begin
        for (int i = 0; i < N; i++) begin
            if (fsum_read[i]) begin
                if (fifo[i].size() == 0) underflow <= 1'b1;
                else void'(fifo[i].pop_front());
                pop_core.push_back(i);
                pop_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < N; i++) begin
            fsum_empty[i]              <= (fifo[i].size() == 0);
            fsum_out[i*SUM_W +: SUM_W] <= (fifo[i].size() == 0) ? '0 : fifo[i][0];
        end
        pop_cnt <= pop_cnt + $countones(fsum_read);
        cyc     <= cyc + 1;
    end

    typedef struct {
        int                      n;
        logic [3:0][SUM_W-1:0]   w;
        logic [SCORE_W-1:0]      thr;
        logic [SCORE_W-1:0]      mrg;
        logic [CLASS_W-1:0]      ebc;
        logic [SCORE_W-1:0]      eb;
        logic [CLASS_W-1:0]      esc;
        logic [SCORE_W-1:0]      es;
        logic [CLASS_W-1:0]      edec;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [SUM_W-1:0] mk(input int c, input int d);
        return {CLASS_W'(c), 4'hA, SCORE_W'(d)};
    endfunction

    function automatic vec_t mkv(input int n, input int c0, input int d0, input int c1,
                                 input int d1, input int c2, input int d2, input int c3,
                                 input int d3, input int thr, input int mrg, input int ebc,
                                 input int eb, input int esc, input int es, input int edec);
        vec_t v;
        v.n    = n;
        v.w[0] = mk(c0, d0);
        v.w[1] = mk(c1, d1);
        v.w[2] = mk(c2, d2);
        v.w[3] = mk(c3, d3);
        v.thr  = SCORE_W'(thr);
        v.mrg  = SCORE_W'(mrg);
        v.ebc  = CLASS_W'(ebc);
        v.eb   = SCORE_W'(eb);
        v.esc  = CLASS_W'(esc);
        v.es   = SCORE_W'(es);
        v.edec = CLASS_W'(edec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_dv(input string name);
        int k = 0;
        while (!decision_valid && k < 100) begin
            @(negedge csi_clk);
            k++;
        end
        n_checks++;
        if (!decision_valid) begin
            n_fail++;
            $display("FAIL %s: decision_valid still 0 after %0d cycles", name, k);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " fsum_read"},      32'(fsum_read),      32'd0);
        chk({tag, " best_score"},     32'(best_score),     32'(S_MAX));
        chk({tag, " best_class"},     32'(best_class),     32'd0);
        chk({tag, " second_score"},   32'(second_score),   32'(S_MAX));
        chk({tag, " second_class"},   32'(second_class),   32'd0);
        chk({tag, " decision"},       32'(decision),       32'(C_REJ));
        chk({tag, " decision_valid"}, 32'(decision_valid), 32'd0);
        chk({tag, " busy"},           32'(busy),           32'd0);
        chk({tag, " done_irq"},       32'(done_irq),       32'd0);
    endtask

    task automatic ack_irq();
        irq_ack = 1'b1;
        @(negedge csi_clk);
        irq_ack = 1'b0;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) fifo[i].delete();
    endtask

    task automatic start(input int cnt, input logic [SCORE_W-1:0] thr,
                         input logic [SCORE_W-1:0] mrg);
        cfg_count     = 16'(cnt);
        cfg_threshold = thr;
        cfg_margin    = mrg;
        init          = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        for (int j = 0; j < v.n; j++) fifo[0].push_back(v.w[j]);
        @(negedge csi_clk);
        start(v.n, v.thr, v.mrg);
        @(negedge csi_clk);
        init = 1'b0;
        wait_dv($sformatf("vec%0d valid", idx));
        chk($sformatf("vec%0d best_score", idx),   32'(best_score),   32'(v.eb));
        chk($sformatf("vec%0d best_class", idx),   32'(best_class),   32'(v.ebc));
        chk($sformatf("vec%0d second_score", idx), 32'(second_score), 32'(v.es));
        chk($sformatf("vec%0d second_class", idx), 32'(second_class), 32'(v.esc));
        chk($sformatf("vec%0d decision", idx),     32'(decision),     32'(v.edec));
        chk($sformatf("vec%0d done_irq", idx),     32'(done_irq),     32'd1);
        chk($sformatf("vec%0d fifo drained", idx), fifo[0].size(),    0);
        repeat (2) @(negedge csi_clk);
        chk($sformatf("vec%0d irq sticky", idx),      32'(done_irq), 32'd1);
        chk($sformatf("vec%0d decision frozen", idx), 32'(decision), 32'(v.edec));
        ack_irq();
        chk($sformatf("vec%0d irq cleared", idx), 32'(done_irq), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int p0;
        int dv_cyc;
        int k;

        vecs[0] = mkv(4, 3,100, 5,40, 7,40, 2,90,   50,10,  5,40,  7,40, 15);
        vecs[1] = mkv(4, 3,100, 5,40, 7,80, 2,90,   50,10,  5,40,  7,80, 5);
        vecs[2] = mkv(1, 9,10,  0,0,  0,0,  0,0,    20,5,   9,10,  0,'h00FF_FFFF, 9);
        vecs[3] = mkv(2, 1,50,  4,60, 0,0,  0,0,    50,10,  1,50,  4,60, 1);
        vecs[4] = mkv(2, 1,51,  4,70, 0,0,  0,0,    50,10,  1,51,  4,70, 15);
        vecs[5] = mkv(2, 6,30,  2,39, 0,0,  0,0,    100,10, 6,30,  2,39, 15);
        vecs[6] = mkv(3, 2,20,  8,20, 3,5,  0,0,    10,15,  3,5,   2,20, 3);
        vecs[7] = mkv(4, 1,400, 2,300, 3,200, 4,100, 150,100, 4,100, 3,200, 4);

        rsi_reset_n   = 1'b0;
        init          = 1'b0;
        irq_ack       = 1'b0;
        cfg_count     = '0;
        cfg_threshold = '0;
        cfg_margin    = '0;
        repeat (3) @(negedge csi_clk);
        rsi_reset_n = 1'b1;
        @(negedge csi_clk);
        chk_reset("post_reset");

        // Round-robin order with every FIFO non-empty, 8 words.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 3; j++)
                fifo[i].push_back(mk(i + 4*j, 200 - 20*j - 3*i));
        @(negedge csi_clk);
        base = pop_core.size();
        start(8, 24'd171, 24'd3);
        @(negedge csi_clk);
        init = 1'b0;
        chk("order busy", 32'(busy), 32'd1);
        wait_dv("order valid");
        dv_cyc = cyc;
        chk("order pop count", pop_core.size() - base, 8);
        for (int j = 0; j < 8; j++) begin
            if (base + j < pop_core.size()) begin
                chk($sformatf("order pop%0d core", j), pop_core[base + j], j % 4);
                chk($sformatf("order pop%0d cycle", j), pop_cyc[base + j], pop_cyc[base] + j);
            end
        end
        if (base + 7 < pop_core.size())
            chk("order latency", dv_cyc - pop_cyc[base + 7], 3);
        chk("order best_score",   32'(best_score),   32'd171);
        chk("order best_class",   32'(best_class),   32'd7);
        chk("order second_score", 32'(second_score), 32'd174);
        chk("order second_class", 32'(second_class), 32'd6);
        chk("order decision",     32'(decision),     32'd7);
        chk("order busy done",    32'(busy),         32'd0);
        repeat (4) @(negedge csi_clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("order fifo%0d untouched", i), fifo[i].size(), 1);
        ack_irq();

        // cfg_count = 0: straight through DECIDE to a reject, no pops.
        clear_fifos();
        fifo[1].push_back(mk(2, 5));
        fifo[1].push_back(mk(2, 5));
        @(negedge csi_clk);
        p0 = pop_cnt;
        start(0, S_MAX, 24'd0);
        @(negedge csi_clk);
        init = 1'b0;
        chk("cnt0 valid c1", 32'(decision_valid), 32'd0);
        @(negedge csi_clk);
        chk("cnt0 valid c2", 32'(decision_valid), 32'd0);
        @(negedge csi_clk);
        chk("cnt0 valid c3", 32'(decision_valid), 32'd1);
        chk("cnt0 decision", 32'(decision), 32'(C_REJ));
        chk("cnt0 best",     32'(best_score), 32'(S_MAX));
        chk("cnt0 no pops",  pop_cnt, p0);
        chk("cnt0 fifo",     fifo[1].size(), 2);

        // Acknowledge held through DONE entry: set wins, then ack clears.
        start(1, S_MAX, 24'd0);
        irq_ack = 1'b1;
        @(negedge csi_clk);
        init = 1'b0;
        wait_dv("ackset valid");
        chk("ackset irq set",  32'(done_irq), 32'd1);
        chk("ackset decision", 32'(decision), 32'd2);
        @(negedge csi_clk);
        chk("ackset irq cleared", 32'(done_irq), 32'd0);
        irq_ack = 1'b0;
        clear_fifos();
        @(negedge csi_clk);

        for (int i = 0; i < 8; i++) run_vec(i);

        // init after 3 of 8 pops restarts the run.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 4; j++)
                fifo[i].push_back(mk(i, 500 + 10*j + i));
        @(negedge csi_clk);
        base = pop_cnt;
        start(8, S_MAX, 24'd0);
        @(negedge csi_clk);
        init = 1'b0;
        k = 0;
        while (pop_cnt - base < 3 && k < 50) begin
            @(negedge csi_clk);
            k++;
        end
        chk("restart first pops", pop_cnt - base, 3);
        base2 = pop_cnt;
        start(8, S_MAX, 24'd0);
        @(negedge csi_clk);
        init = 1'b0;
        chk("restart cleared best", 32'(best_score), 32'(S_MAX));
        chk("restart busy", 32'(busy), 32'd1);
        chk("restart valid low", 32'(decision_valid), 32'd0);
        wait_dv("restart valid");
        chk("restart pops", pop_cnt - base2, 8);
        chk("restart best", 32'(best_score), 32'd500);
        ack_irq();

        // Reset for 2 cycles mid-COLLECT.
        clear_fifos();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 3; j++)
                fifo[i].push_back(mk(i, 50 + j));
        @(negedge csi_clk);
        base = pop_cnt;
        start(8, S_MAX, 24'd0);
        @(negedge csi_clk);
        init = 1'b0;
        k = 0;
        while (pop_cnt - base < 2 && k < 50) begin
            @(negedge csi_clk);
            k++;
        end
        rsi_reset_n = 1'b0;
        repeat (2) @(negedge csi_clk);
        chk_reset("in_reset");
        rsi_reset_n = 1'b1;
        @(negedge csi_clk);
        chk_reset("after_reset");
        p0 = pop_cnt;
        repeat (3) @(negedge csi_clk);
        chk("idle no pops", pop_cnt, p0);
        chk("no underflow", 32'(underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
